hssi_mb_cmd_engine: RTL and testbench
=====================================

# hssi_mb_cmd_engine

Multi-port mailbox command engine for the HSSI traffic-controller path. The host writes a command, address and write data into a four-word mailbox CSR window. The engine then performs one indirect read or write to the traffic controller of the selected Ethernet port over a req/ack bus, with timeout protection and sticky status. It generalises the single-channel mailbox to NUM_PORTS controllers, per-port select, timeout and error reporting, and sits between the AFU CSR decoder and the per-port traffic generator/monitor register files.

## Interface
- NUM_PORTS, 8: number of traffic-controller ports (1..16).
- ADDR_W, 16: indirect register address width.
- DATA_W, 32: indirect register data width (fixed 32 for CSR window).
- TIMEOUT_CYC, 1024: cycles to wait for ack before abort (≥2).
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- csr_wr  in  1  host write strobe, one cycle.
- csr_rd  in  1  host read strobe, one cycle.
- csr_addr  in  4  byte offset: 0x0 CMD, 0x4 ADDRESS, 0x8 RDDATA, 0xC WRDATA.
- csr_wdata  in  32  host write data.
- csr_rdata  out  32  host read data, valid with csr_rvalid.
- csr_rvalid  out  1  read response strobe.
- tc_req  out  NUM_PORTS  one-hot request, held until ack or timeout.
- tc_wr  out  1  1 = write, 0 = read; valid while any tc_req bit is set.
- tc_addr  out  ADDR_W  indirect address.
- tc_wdata  out  DATA_W  indirect write data.
- tc_ack  in  NUM_PORTS  per-port completion, one cycle.
- tc_rdata  in  NUM_PORTS*DATA_W  per-port read data, slice p valid with tc_ack[p].

## Operation
- CMD write fields: [1:0] cmd (0 NOOP, 1 RD, 2 WR, 3 reserved = NOOP), [11:8] port.
- CMD read fields: [0] busy, [1] done, [2] timeout, [3] bad_port, [4] overrun, [11:8] last port, rest 0.
- ADDRESS and WRDATA are plain R/W registers, writable anytime. They are captured into tc_addr/tc_wdata only when a command is accepted. RDDATA is read-only; writes to it are ignored.
- FSM states:
  - IDLE: a CMD write is accepted and clears done, timeout, bad_port and overrun.
    - RD/WR with port < NUM_PORTS goes to REQ.
    - RD/WR with port ≥ NUM_PORTS goes to IDLE with done=1, bad_port=1; no request, RDDATA unchanged.
    - NOOP stays in IDLE; it clears status only.
  - REQ: tc_req[port]=1, timer counts from 0.
    - tc_ack[port] moves to IDLE with done=1. On RD, RDDATA ← tc_rdata slice.
    - Timer reaching TIMEOUT_CYC−1 without ack moves to IDLE with done=1, timeout=1, RDDATA ← 32'hFFFF_FFFF.
- Ack and timeout in the same cycle: ack wins, timeout=0.
- tc_ack bits for non-selected ports, or any ack in IDLE, are ignored.
- A CMD write while busy is dropped, sets overrun=1, and does not disturb the transaction in flight. overrun is not cleared on completion.
- An ADDRESS/WRDATA write while busy updates the register but not the in-flight tc_addr/tc_wdata.
- Reset values: all registers and outputs 0, FSM IDLE, tc_req=0, csr_rvalid=0.
- Reset asserted mid-REQ drops tc_req at that edge. The transaction is abandoned and the status is not set.

## Timing
- CSR read: csr_rvalid and csr_rdata one cycle after csr_rd. Reads of unmapped offsets return 0.
- Simultaneous csr_rd and csr_wr to the same offset: the read returns the pre-write value.
- CMD write at edge T: tc_req high from T+1.
- Ack sampled high at edge A: tc_req low from A+1; done, busy=0 and RDDATA visible from A+1.
- Minimum cmd-to-done latency is 2 cycles (ack in the first REQ cycle).
- Timeout: tc_req high for exactly TIMEOUT_CYC cycles, then low, with done/timeout set on the same edge.
- tc_addr, tc_wdata and tc_wr are stable for the whole REQ period.
- A new command can be accepted on the edge after done is set.

## Test plan
- Write path: ADDRESS=0x0005, WRDATA=0x1234_5678, CMD=0x0302 → tc_req=8'b0000_1000, tc_wr=1, tc_addr=0x5, tc_wdata=0x12345678. Ack after 3 cycles → CMD reads 0x0000_0302 (done, port 3).
- Read path: port 7, RD, tc_rdata slice 7 = 0xCAFE_F00D, ack in first REQ cycle → done 2 cycles after CMD write, RDDATA=0xCAFEF00D, tc_req one cycle wide.
- Timeout: TIMEOUT_CYC=16, RD port 0, no ack → tc_req high exactly 16 cycles, status 0x0000_0006, RDDATA=0xFFFFFFFF. An ack on the same cycle as the last timer count gives status 0x2.
- Bad port: NUM_PORTS=8, CMD=0x0901 → no tc_req, status 0x0000_090A, RDDATA unchanged.
- Overrun and isolation: second CMD while busy, plus ADDRESS rewrite → in-flight tc_addr/port unchanged, overrun=1 after completion. A wrong-port ack is ignored, and a NOOP then clears the status to 0.
- Reset mid-REQ: assert rst for 1 cycle during REQ → tc_req=0 and all status 0 at that edge, RDDATA=0. The following RD works normally.

Source files
------------

// File: rtl/hssi_mb_cmd_engine_if.sv
// Bus bundle for the HSSI mailbox command engine.
//   csr_*  : host CSR window (one-cycle write/read strobes, registered read response)
//   tc_*   : indirect req/ack bus to NUM_PORTS traffic controllers
// master : host / traffic-controller side (drives strobes and acks)
// slave  : the command engine
interface hssi_mb_cmd_engine_if #(
  parameter int unsigned NUM_PORTS = 8,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32
);
  logic                          csr_wr;
  logic                          csr_rd;
  logic [3:0]                    csr_addr;
  logic [31:0]                   csr_wdata;
  logic [31:0]                   csr_rdata;
  logic                          csr_rvalid;
  logic [NUM_PORTS-1:0]          tc_req;
  logic                          tc_wr;
  logic [ADDR_W-1:0]             tc_addr;
  logic [DATA_W-1:0]             tc_wdata;
  logic [NUM_PORTS-1:0]          tc_ack;
  logic [NUM_PORTS*DATA_W-1:0]   tc_rdata;

  modport master (
    output csr_wr, csr_rd, csr_addr, csr_wdata, tc_ack, tc_rdata,
    input  csr_rdata, csr_rvalid, tc_req, tc_wr, tc_addr, tc_wdata
  );

  modport slave (
    input  csr_wr, csr_rd, csr_addr, csr_wdata, tc_ack, tc_rdata,
    output csr_rdata, csr_rvalid, tc_req, tc_wr, tc_addr, tc_wdata
  );
endinterface

// File: rtl/hssi_mb_cmd_engine.sv
// Multi-port mailbox command engine.
// The host fills ADDRESS/WRDATA and writes CMD; the engine issues one indirect read or
// write to the selected traffic-controller port, waits for its ack (or times out) and
// reports sticky status in CMD.
// Ports:
//   clk  : single clock
//   rst  : synchronous active-high reset
//   bus  : hssi_mb_cmd_engine_if.slave (CSR window + tc req/ack bus)
// CSR map: 0x0 CMD (wr: [1:0] op, [11:8] port; rd: busy/done/timeout/bad_port/overrun,
//          [11:8] last port), 0x4 ADDRESS, 0x8 RDDATA (ro), 0xC WRDATA.
module hssi_mb_cmd_engine #(
  parameter int unsigned NUM_PORTS   = 8,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                 clk,
  input logic                 rst,
  hssi_mb_cmd_engine_if.slave bus
);

  localparam logic StIdle = 1'b0;
  localparam logic StReq  = 1'b1;

  localparam int unsigned     TimerW    = $clog2(TIMEOUT_CYC);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);

  logic              state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic [DATA_W-1:0] rddata_q, rddata_d;
  logic [ADDR_W-1:0] tc_addr_q, tc_addr_d;
  logic [DATA_W-1:0] tc_wdata_q, tc_wdata_d;
  logic              tc_wr_q, tc_wr_d;
  // Last accepted port; doubles as the in-flight port since busy CMD writes are dropped.
  logic [3:0]        port_q, port_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              bad_port_q, bad_port_d;
  logic              overrun_q, overrun_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              wr_cmd, wr_addr, wr_wdata;
  logic [1:0]        cmd_op;
  logic [3:0]        cmd_port;
  logic              cmd_xfer, port_ok;
  logic [NUM_PORTS-1:0] req_vec;
  logic [DATA_W-1:0] ack_data;
  logic              ack_hit;
  logic [31:0]       status;
  logic              unused_wdata;

  assign wr_cmd   = bus.csr_wr && (bus.csr_addr == 4'h0);
  assign wr_addr  = bus.csr_wr && (bus.csr_addr == 4'h4);
  assign wr_wdata = bus.csr_wr && (bus.csr_addr == 4'hC);

  assign cmd_op   = bus.csr_wdata[1:0];
  assign cmd_port = bus.csr_wdata[11:8];
  assign cmd_xfer = (cmd_op == 2'd1) || (cmd_op == 2'd2);
  assign port_ok  = 32'(cmd_port) < NUM_PORTS;

  // Only some CMD bits are meaningful; the rest are don't-care on write.
  assign unused_wdata = ^bus.csr_wdata;

  // One-hot request and the matching read-data slice, built with constant indices so the
  // 4-bit port field never has to index a narrower vector.
  always_comb begin
    req_vec  = '0;
    ack_data = '0;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      if ((state_q == StReq) && (port_q == 4'(p))) begin
        req_vec[p] = 1'b1;
        ack_data   = bus.tc_rdata[p*DATA_W +: DATA_W];
      end
    end
  end

  // Acks on non-selected ports, or any ack while idle, fall out of this mask.
  assign ack_hit = |(req_vec & bus.tc_ack);

  always_comb begin
    status       = '0;
    status[0]    = (state_q == StReq);
    status[1]    = done_q;
    status[2]    = timeout_q;
    status[3]    = bad_port_q;
    status[4]    = overrun_q;
    status[11:8] = port_q;
  end

  // Next-state logic for the transaction FSM and status.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tc_addr_d  = tc_addr_q;
    tc_wdata_d = tc_wdata_q;
    tc_wr_d    = tc_wr_q;
    port_d     = port_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    bad_port_d = bad_port_q;
    overrun_d  = overrun_q;
    rddata_d   = rddata_q;

    if (state_q == StIdle) begin
      if (wr_cmd) begin
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        bad_port_d = 1'b0;
        overrun_d  = 1'b0;
        port_d     = cmd_port;
        if (cmd_xfer) begin
          if (port_ok) begin
            state_d    = StReq;
            timer_d    = '0;
            tc_addr_d  = addr_q;
            tc_wdata_d = wrdata_q;
            tc_wr_d    = (cmd_op == 2'd2);
          end else begin
            done_d     = 1'b1;
            bad_port_d = 1'b1;
          end
        end
      end
    end else begin
      if (wr_cmd) begin
        overrun_d = 1'b1;
      end
      // Ack takes priority over a timeout landing in the same cycle.
      if (ack_hit) begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (!tc_wr_q) begin
          rddata_d = ack_data;
        end
      end else if (timer_q == TimerLast) begin
        state_d   = StIdle;
        done_d    = 1'b1;
        timeout_d = 1'b1;
        rddata_d  = '1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Host-visible registers and the registered read response (sees pre-write values).
  always_comb begin
    addr_d   = wr_addr ? bus.csr_wdata[ADDR_W-1:0] : addr_q;
    wrdata_d = wr_wdata ? bus.csr_wdata[DATA_W-1:0] : wrdata_q;
    rvalid_d = bus.csr_rd;
    rdata_d  = '0;
    if (bus.csr_rd) begin
      case (bus.csr_addr)
        4'h0:    rdata_d = status;
        4'h4:    rdata_d = 32'(addr_q);
        4'h8:    rdata_d = 32'(rddata_q);
        4'hC:    rdata_d = 32'(wrdata_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      addr_q     <= '0;
      wrdata_q   <= '0;
      rddata_q   <= '0;
      tc_addr_q  <= '0;
      tc_wdata_q <= '0;
      tc_wr_q    <= 1'b0;
      port_q     <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      bad_port_q <= 1'b0;
      overrun_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      wrdata_q   <= wrdata_d;
      rddata_q   <= rddata_d;
      tc_addr_q  <= tc_addr_d;
      tc_wdata_q <= tc_wdata_d;
      tc_wr_q    <= tc_wr_d;
      port_q     <= port_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      bad_port_q <= bad_port_d;
      overrun_q  <= overrun_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.tc_req     = req_vec;
  assign bus.tc_wr      = tc_wr_q;
  assign bus.tc_addr    = tc_addr_q;
  assign bus.tc_wdata   = tc_wdata_q;
  assign bus.csr_rvalid = rvalid_q;
  assign bus.csr_rdata  = rdata_q;

endmodule

// File: tb/tb_hssi_mb_cmd_engine.sv
// Testbench for hssi_mb_cmd_engine: directed CSR/ack sequences, a transaction-level
// mailbox model checked against the DUT on every falling edge, and literal expectations.
module tb_hssi_mb_cmd_engine;
  localparam int unsigned NP = 8;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hssi_mb_cmd_engine_if #(.NUM_PORTS(NP), .ADDR_W(16), .DATA_W(32)) bus ();

  hssi_mb_cmd_engine #(
    .NUM_PORTS  (NP),
    .ADDR_W     (16),
    .DATA_W     (32),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic        m_busy = 0, m_wr = 0, m_done = 0, m_to = 0, m_bad = 0, m_ovr = 0;
  logic        m_rvalid = 0;
  logic [31:0] m_rdata = 0;
  int          m_port = 0, m_elapsed = 0;
  logic [3:0]  m_last = 0;
  logic [15:0] m_addr = 0, r_addr = 0;
  logic [31:0] m_wdata = 0, r_wdata = 0, r_rddata = 0;

  function automatic logic [31:0] m_csr(input logic [3:0] a);
    case (a)
      4'h0:    return {20'd0, m_last, 3'd0, m_ovr, m_bad, m_to, m_done, m_busy};
      4'h4:    return {16'd0, r_addr};
      4'h8:    return r_rddata;
      4'hC:    return r_wdata;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic       was_busy;
    logic [1:0] op;
    if (rst) begin
      m_busy = 0; m_wr = 0; m_done = 0; m_to = 0; m_bad = 0; m_ovr = 0;
      m_rvalid = 0; m_rdata = 0; m_port = 0; m_elapsed = 0; m_last = 0;
      m_addr = 0; r_addr = 0; m_wdata = 0; r_wdata = 0; r_rddata = 0;
    end else begin
      m_rvalid = bus.csr_rd;
      if (bus.csr_rd) m_rdata = m_csr(bus.csr_addr);
      was_busy = m_busy;
      if (m_busy) begin
        if (bus.tc_ack[m_port]) begin
          m_busy = 0;
          m_done = 1;
          if (!m_wr) r_rddata = bus.tc_rdata[m_port*32 +: 32];
        end else if (m_elapsed == int'(TO) - 1) begin
          m_busy   = 0;
          m_done   = 1;
          m_to     = 1;
          r_rddata = 32'hFFFF_FFFF;
        end else begin
          m_elapsed++;
        end
      end
      if (bus.csr_wr && bus.csr_addr == 4'h0) begin
        if (was_busy) begin
          m_ovr = 1;
        end else begin
          m_done = 0; m_to = 0; m_bad = 0; m_ovr = 0;
          m_last = bus.csr_wdata[11:8];
          op     = bus.csr_wdata[1:0];
          if (op == 2'd1 || op == 2'd2) begin
            if (int'(bus.csr_wdata[11:8]) < int'(NP)) begin
              m_busy    = 1;
              m_port    = int'(bus.csr_wdata[11:8]);
              m_wr      = (op == 2'd2);
              m_addr    = r_addr;
              m_wdata   = r_wdata;
              m_elapsed = 0;
            end else begin
              m_done = 1;
              m_bad  = 1;
            end
          end
        end
      end
      if (bus.csr_wr && bus.csr_addr == 4'h4) r_addr = bus.csr_wdata[15:0];
      if (bus.csr_wr && bus.csr_addr == 4'hC) r_wdata = bus.csr_wdata;
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin : compare
    logic [7:0] exp_req;
    exp_req = 8'h00;
    if (m_busy) exp_req[m_port] = 1'b1;
    chk("tc_req", 32'(bus.tc_req), 32'(exp_req));
    chk("csr_rvalid", 32'(bus.csr_rvalid), 32'(m_rvalid));
    if (m_rvalid) chk("csr_rdata", bus.csr_rdata, m_rdata);
    if (m_busy) begin
      chk("tc_wr", 32'(bus.tc_wr), 32'(m_wr));
      chk("tc_addr", 32'(bus.tc_addr), 32'(m_addr));
      chk("tc_wdata", bus.tc_wdata, m_wdata);
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
    bus.csr_wr = 1'b1; bus.csr_addr = a; bus.csr_wdata = d;
    @(negedge clk);
    bus.csr_wr = 1'b0;
  endtask

  task automatic rd_expect(input string name, input logic [3:0] a, input logic [31:0] exp);
    bus.csr_rd = 1'b1; bus.csr_addr = a;
    @(negedge clk);
    bus.csr_rd = 1'b0;
    chk({name, "_rvalid"}, 32'(bus.csr_rvalid), 32'd1);
    chk(name, bus.csr_rdata, exp);
  endtask

  task automatic pulse_ack(input logic [7:0] v);
    bus.tc_ack = v;
    @(negedge clk);
    bus.tc_ack = '0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt;
    bus.csr_wr = 0; bus.csr_rd = 0; bus.csr_addr = 0; bus.csr_wdata = 0;
    bus.tc_ack = '0; bus.tc_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("reset_tc_req", 32'(bus.tc_req), 32'd0);
    rd_expect("reset_cmd", 4'h0, 32'h0);
    rd_expect("reset_rddata", 4'h8, 32'h0);

    // Simultaneous read/write to ADDRESS returns the old value; RDDATA is read-only
    bus.csr_rd = 1; bus.csr_wr = 1; bus.csr_addr = 4'h4; bus.csr_wdata = 32'h42;
    @(negedge clk);
    bus.csr_rd = 0; bus.csr_wr = 0;
    chk("rd_during_wr", bus.csr_rdata, 32'h0);
    rd_expect("addr_after_wr", 4'h4, 32'h42);
    rd_expect("unmapped", 4'h1, 32'h0);
    csr_write(4'h8, 32'hDEAD_BEEF);
    rd_expect("rddata_ro", 4'h8, 32'h0);

    // Write path, port 3
    csr_write(4'h4, 32'h0005);
    csr_write(4'hC, 32'h1234_5678);
    csr_write(4'h0, 32'h0000_0302);
    chk("wr_tc_req", 32'(bus.tc_req), 32'h08);
    chk("wr_tc_wr", 32'(bus.tc_wr), 32'd1);
    chk("wr_tc_addr", 32'(bus.tc_addr), 32'h5);
    chk("wr_tc_wdata", bus.tc_wdata, 32'h1234_5678);
    rd_expect("wr_busy", 4'h0, 32'h0301);
    pulse_ack(8'h08);
    chk("wr_req_drop", 32'(bus.tc_req), 32'd0);
    rd_expect("wr_done", 4'h0, 32'h0302);

    // Read path, port 7, ack in first REQ cycle
    bus.tc_rdata[7*32 +: 32] = 32'hCAFE_F00D;
    csr_write(4'h0, 32'h0701);
    chk("rd_tc_req", 32'(bus.tc_req), 32'h80);
    pulse_ack(8'h80);
    chk("rd_req_one_cycle", 32'(bus.tc_req), 32'd0);
    rd_expect("rd_done", 4'h0, 32'h0702);
    rd_expect("rd_data", 4'h8, 32'hCAFE_F00D);

    // Timeout, port 0, no ack
    csr_write(4'h0, 32'h0001);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.tc_req[0]) cnt++;
      @(negedge clk);
    end
    chk("to_req_cycles", 32'(cnt), 32'(TO));
    rd_expect("to_status", 4'h0, 32'h0006);
    rd_expect("to_rddata", 4'h8, 32'hFFFF_FFFF);

    // Ack on the last timer cycle beats timeout
    bus.tc_rdata[0 +: 32] = 32'h1357_2468;
    csr_write(4'h0, 32'h0001);
    repeat (TO - 1) @(negedge clk);
    chk("late_req_still_high", 32'(bus.tc_req), 32'h01);
    pulse_ack(8'h01);
    rd_expect("late_ack_status", 4'h0, 32'h0002);
    rd_expect("late_ack_data", 4'h8, 32'h1357_2468);

    // Bad port
    csr_write(4'h0, 32'h0901);
    chk("bad_no_req", 32'(bus.tc_req), 32'd0);
    rd_expect("bad_status", 4'h0, 32'h090A);
    rd_expect("bad_rddata", 4'h8, 32'h1357_2468);

    // Overrun and isolation
    csr_write(4'h4, 32'h00AA);
    csr_write(4'h0, 32'h0202);
    csr_write(4'h0, 32'h0501);
    csr_write(4'h4, 32'h00BB);
    chk("ovr_tc_req", 32'(bus.tc_req), 32'h04);
    chk("ovr_tc_addr", 32'(bus.tc_addr), 32'hAA);
    pulse_ack(8'h01);
    chk("wrong_ack_ignored", 32'(bus.tc_req), 32'h04);
    pulse_ack(8'h04);
    rd_expect("ovr_status", 4'h0, 32'h0212);
    rd_expect("ovr_addr_reg", 4'h4, 32'hBB);
    csr_write(4'h0, 32'h0000);
    rd_expect("noop_clears", 4'h0, 32'h0);

    // Reset mid-REQ
    csr_write(4'h0, 32'h0101);
    chk("pre_rst_req", 32'(bus.tc_req), 32'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_drops_req", 32'(bus.tc_req), 32'd0);
    rd_expect("rst_status", 4'h0, 32'h0);
    rd_expect("rst_rddata", 4'h8, 32'h0);
    bus.tc_rdata[1*32 +: 32] = 32'h600D_CAFE;
    csr_write(4'h0, 32'h0101);
    pulse_ack(8'h02);
    rd_expect("post_rst_status", 4'h0, 32'h0102);
    rd_expect("post_rst_data", 4'h8, 32'h600D_CAFE);

    // Ack while idle is ignored
    bus.tc_rdata[1*32 +: 32] = 32'h0BAD_0BAD;
    pulse_ack(8'h02);
    rd_expect("idle_ack_ignored", 4'h8, 32'h600D_CAFE);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
